uart_inst_rx: RTL and testbench

8N1 UART receiver that turns bytes arriving on the board serial input (RsRx) into instruction words for the calculator datapath. It is the receive-side counterpart of the existing UART transmit path that returns SEND results. It presents each byte as `inst_wd` with a single-cycle `inst_vld`, the same interface the switch/button front end drives. Instructions can therefore be issued from the host serial link instead of `sw`/`btnS`.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync2.sv | 24 ++
 rtl/uart_inst_rx.sv | 124 ++++++++++++
 tb/tb_uart_inst_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit paths.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEF = 100;
  localparam int unsigned DATA_BITS             = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync2 #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_inst_rx.sv
// 8N1 UART receiver delivering each good byte as an instruction word with a one-cycle valid.
module uart_inst_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] inst_wd,
  output logic                 inst_vld,
  output logic                 frm_err,
  output logic                 busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  rx_state_t            state, state_nxt;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] sh;
  logic                 armed;

  logic cnt_done_c, half_done_c, last_bit_c;
  logic shift_c, good_stop_c, bad_stop_c;

  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign cnt_done_c  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_done_c = (cnt == CNT_W'(HALF - 1));
  assign last_bit_c  = (idx == IDX_W'(DATA_BITS - 1));

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt   = state;
    shift_c     = 1'b0;
    good_stop_c = 1'b0;
    bad_stop_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !rx_s) state_nxt = START;
      end
      START: begin
        if (half_done_c) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_done_c) begin
          shift_c = 1'b1;
          if (last_bit_c) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt_done_c) begin
          good_stop_c = rx_s;
          bad_stop_c  = !rx_s;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and receive datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      armed    <= 1'b0;
      inst_wd  <= '0;
      inst_vld <= 1'b0;
      frm_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inst_vld <= good_stop_c;
      frm_err  <= bad_stop_c;
      busy     <= (state_nxt != IDLE);

      if (good_stop_c) inst_wd <= sh;

      if (shift_c) begin
        sh  <= {rx_s, sh[DATA_BITS-1:1]};
        idx <= idx + IDX_W'(1);
      end

      unique case (state)
        IDLE: begin
          // While unarmed, cnt measures how long the line has been idle-high
          if (armed || !rx_s) begin
            cnt <= '0;
          end else if (cnt_done_c) begin
            cnt   <= '0;
            armed <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: begin
          if (half_done_c) begin
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA, STOP: begin
          cnt <= cnt_done_c ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_inst_rx.sv
// Directed bench for uart_inst_rx: table of single frames plus back-to-back, glitch and reset-abort sequences.
module tb_uart_inst_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frm_err;
  logic       busy;

  uart_inst_rx #(.CLKS_PER_BIT(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .inst_wd  (inst_wd),
    .inst_vld (inst_vld),
    .frm_err  (frm_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  int   nvld = 0, nerr = 0, viol = 0, busy_cnt = 0, vld_cyc = 0;
  logic [7:0] wd_at_vld = 8'h00;
  logic prev_vld = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if ((inst_vld && frm_err) || (inst_vld && prev_vld) || (frm_err && prev_err))
      viol = viol + 1;
    if (inst_vld) begin
      nvld      = nvld + 1;
      vld_cyc   = cyc;
      wd_at_vld = inst_wd;
    end
    if (frm_err) nerr = nerr + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    prev_vld = inst_vld;
    prev_err = frm_err;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t_fall = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int per);
    t_fall = cyc;
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(per);
    end
    rx = stop_ok;
    tick(per);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         per;
    logic [7:0] exp_wd;
    int         exp_vld;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s_v, s_e, s_x, s_b, v1;
    logic [7:0] w1;

    vecs[0] = '{8'h34, 1'b1, 100, 8'h34, 1, 0};
    vecs[1] = '{8'h12, 1'b1, 100, 8'h12, 1, 0};
    vecs[2] = '{8'hC0, 1'b0, 100, 8'h12, 0, 1};
    vecs[3] = '{8'h3C, 1'b1,  96, 8'h3C, 1, 0};
    vecs[4] = '{8'h3C, 1'b1, 104, 8'h3C, 1, 0};
    vecs[5] = '{8'hFF, 1'b1, 100, 8'hFF, 1, 0};
    vecs[6] = '{8'h00, 1'b1, 100, 8'h00, 1, 0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_inst_wd",  int'(inst_wd),  0);
    chk("reset_inst_vld", int'(inst_vld), 0);
    chk("reset_frm_err",  int'(frm_err),  0);
    chk("reset_busy",     int'(busy),     0);
    rst = 1'b0;
    tick(150);

    // Single frames from the table
    for (int i = 0; i < 7; i++) begin
      s_v = nvld; s_e = nerr; s_x = viol;
      send_byte(vecs[i].data, vecs[i].stop_ok, vecs[i].per);
      tick(150);
      chk($sformatf("vec%0d_vld_count", i), nvld - s_v, vecs[i].exp_vld);
      chk($sformatf("vec%0d_err_count", i), nerr - s_e, vecs[i].exp_err);
      chk($sformatf("vec%0d_inst_wd", i), int'(inst_wd), int'(vecs[i].exp_wd));
      chk($sformatf("vec%0d_pulse_shape", i), viol - s_x, 0);
      chk($sformatf("vec%0d_busy_idle", i), int'(busy), 0);
      if (vecs[i].exp_vld == 1 && vecs[i].per == 100)
        chk_rng($sformatf("vec%0d_latency", i), vld_cyc - t_fall, 950, 958);
    end

    // Back-to-back frames, one stop bit between
    s_v = nvld; s_e = nerr; s_x = viol;
    send_byte(8'h9B, 1'b1, 100);
    v1 = vld_cyc;
    w1 = wd_at_vld;
    send_byte(8'h70, 1'b1, 100);
    tick(150);
    chk("b2b_vld_count", nvld - s_v, 2);
    chk("b2b_err_count", nerr - s_e, 0);
    chk("b2b_first_wd", int'(w1), 8'h9B);
    chk("b2b_second_wd", int'(inst_wd), 8'h70);
    chk_rng("b2b_spacing", vld_cyc - v1, 998, 1002);
    chk("b2b_pulse_shape", viol - s_x, 0);

    // 20-cycle low glitch
    s_v = nvld; s_e = nerr; s_b = busy_cnt;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(200);
    chk("glitch_vld_count", nvld - s_v, 0);
    chk("glitch_err_count", nerr - s_e, 0);
    chk_rng("glitch_busy_cycles", busy_cnt - s_b, 1, 54);
    chk("glitch_busy_end", int'(busy), 0);

    // Reset in the middle of 0x55, line held low afterwards, then 0xA5
    s_v = nvld; s_e = nerr;
    rx = 1'b0; tick(100);
    rx = 1'b1; tick(100);
    rx = 1'b0; tick(100);
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    chk("abort_inst_wd_reset", int'(inst_wd), 0);
    tick(300);
    chk("abort_busy_low_line", int'(busy), 0);
    chk("abort_vld_count", nvld - s_v, 0);
    chk("abort_err_count", nerr - s_e, 0);
    rx = 1'b1;
    tick(150);
    send_byte(8'hA5, 1'b1, 100);
    tick(150);
    chk("after_abort_vld_count", nvld - s_v, 1);
    chk("after_abort_err_count", nerr - s_e, 0);
    chk("after_abort_inst_wd", int'(inst_wd), 8'hA5);
    chk_rng("after_abort_latency", vld_cyc - t_fall, 950, 958);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
